hc4_dbg_ctrl: RTL and testbench
===============================

HC4_DBG_CTRL -- requirements
Module: hc4_dbg_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 12, program-counter/program-address width.
REQ-002 SHALL have parameter INSN_W, default 8, instruction/program-word width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 nReset  in  1  reset, synchronous, active-low.
REQ-005 cmd_valid  in  1  host command present.
REQ-006 cmd_ready  out  1  command accepted on the cycle where cmd_valid & cmd_ready.
REQ-007 cmd_op  in  3  opcode: 0 CPU_RST, 1 ADDR_HI, 2 ADDR_LO, 3 WRITE, 4 RUN, 5 STEP, 6 HALT, 7 BP.
REQ-008 cmd_data  in  INSN_W  command operand.
REQ-009 pc_in  in  PC_W  CPU program counter (hc4 pc_out).
REQ-010 cpu_nReset  out  1  CPU reset, active-low.
REQ-011 cpu_clk_en  out  1  CPU clock enable; CPU advances one instruction per cycle when high.
REQ-012 prog_we, prog_addr[PC_W], prog_wdata[INSN_W]  out  program-memory write port.
REQ-013 halted  out  1  high in LOAD or HALT state.
REQ-014 bp_hit  out  1  sticky, last stop caused by breakpoint.
REQ-015 cmd_err  out  1  one-cycle pulse when an accepted command is illegal in the current state.

Function
REQ-016 SHALL implement states LOAD, RUN, STEP, HALT.
REQ-017 LOAD: cpu_nReset=0, cpu_clk_en=0; HALT: cpu_nReset=1, cpu_clk_en=0.
REQ-018 cmd_ready SHALL be 1 in LOAD, RUN, HALT and 0 in STEP.
REQ-019 ADDR_HI SHALL set load_addr[11:8]=cmd_data[3:0]; ADDR_LO SHALL set load_addr[7:0]=cmd_data.
REQ-020 WRITE SHALL drive prog_we=1 for exactly the next cycle with prog_addr=load_addr, prog_wdata=cmd_data; then load_addr increments, 0xFFF wrapping to 0x000.
REQ-021 ADDR_HI, ADDR_LO, WRITE, BP accepted in RUN SHALL have no effect and pulse cmd_err next cycle.
REQ-022 RUN from LOAD or HALT: next cycle state RUN, cpu_nReset=1, cpu_clk_en=1, bp_hit cleared.
REQ-023 STEP from LOAD or HALT: cpu_clk_en=1 for exactly one cycle (cpu_nReset=1), then HALT; STEP ignores the breakpoint.
REQ-024 HALT in RUN: next cycle HALT, cpu_clk_en=0; HALT in LOAD/HALT: no effect, no error.
REQ-025 CPU_RST from any accepting state: next cycle LOAD; load_addr, bp settings retained.
REQ-026 BP SHALL set bp_addr=load_addr and bp_en=cmd_data[0].
REQ-027 In RUN, cpu_clk_en SHALL be combinationally 0 when bp_en & pc_in==bp_addr, except the first RUN cycle (resume masking); on such a match, next cycle HALT, bp_hit=1; instruction at bp_addr not executed.
REQ-028 RUN or STEP while already in RUN SHALL pulse cmd_err, no state change.
REQ-029 Accepted HALT coinciding with breakpoint match: HALT state, bp_hit=1.

Reset
REQ-030 On nReset=0 at a rising edge: state LOAD, cpu_nReset=0, cpu_clk_en=0, prog_we=0, prog_addr=0, prog_wdata=0, load_addr=0, bp_addr=0, bp_en=0, bp_hit=0, cmd_err=0, halted=1, cmd_ready=1 (first cycle after release).
REQ-031 Reset asserted during RUN, STEP or a pending write SHALL abort it; no prog_we after the reset edge.

Structure
REQ-032 Opcode constants and state encoding SHALL live in shared package hc4_dbg_pkg.
REQ-033 No sub-module; breakpoint comparator and command decode inline.

Verification
REQ-034 Reset, ADDR_HI 0x0, ADDR_LO 0xFE, WRITE 0xA1, WRITE 0xB2 -> prog_we pulses at 0x0FE=0xA1, 0x0FF=0xB2; halted=1, cpu_nReset=0 throughout.
REQ-035 ADDR 0xFFF, WRITE x2 -> writes at 0xFFF then 0x000.
REQ-036 From LOAD, STEP -> cpu_clk_en high exactly 1 cycle, cpu_nReset=1, then halted=1, cmd_ready low only during STEP cycle.
REQ-037 ADDR 0x005, BP data 0x01, RUN, CPU pc_in reaches 0x005 -> cpu_clk_en=0 that cycle, next cycle HALT, bp_hit=1; RUN again -> pc_in advances past 0x005, bp_hit=0.
REQ-038 In RUN, WRITE 0x33 -> no prog_we, cmd_err pulse 1 cycle; HALT -> halted=1 next cycle.
REQ-039 nReset low mid-RUN for one edge -> state LOAD, cpu_nReset=0, bp_en=0, load_addr=0.

Source files
------------

// File: rtl/hc4_dbg_pkg.sv
// Shared opcode constants and controller state encoding for the hc4 debug controller.
package hc4_dbg_pkg;

   // Host command opcodes carried on cmd_op.
   typedef enum logic [2:0] {
      OP_CPU_RST = 3'd0,
      OP_ADDR_HI = 3'd1,
      OP_ADDR_LO = 3'd2,
      OP_WRITE   = 3'd3,
      OP_RUN     = 3'd4,
      OP_STEP    = 3'd5,
      OP_HALT    = 3'd6,
      OP_BP      = 3'd7
   } dbg_op_e;

   // Controller states.
   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_HALT = 2'd3
   } dbg_state_e;

   // True in the states where the CPU is stopped and memory may be loaded.
   function automatic logic is_stopped(input dbg_state_e s);
      return (s == ST_LOAD) || (s == ST_HALT);
   endfunction

endpackage

// File: rtl/hc4_dbg_ctrl.sv
// Debug/load controller for the hc4 CPU: program loading, run/step/halt and
// a single-address breakpoint.
module hc4_dbg_ctrl
   import hc4_dbg_pkg::*;
#(
   parameter int PC_W   = 12,
   parameter int INSN_W = 8
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [INSN_W-1:0] cmd_data,
   input  logic [PC_W-1:0]   pc_in,
   output logic              cpu_nReset,
   output logic              cpu_clk_en,
   output logic              prog_we,
   output logic [PC_W-1:0]   prog_addr,
   output logic [INSN_W-1:0] prog_wdata,
   output logic              halted,
   output logic              bp_hit,
   output logic              cmd_err
);

   dbg_state_e        state_q,      state_d;
   logic [PC_W-1:0]   load_addr_q,  load_addr_d;
   logic [PC_W-1:0]   bp_addr_q,    bp_addr_d;
   logic              bp_en_q,      bp_en_d;
   logic              bp_hit_q,     bp_hit_d;
   logic              prog_we_q,    prog_we_d;
   logic [PC_W-1:0]   prog_addr_q,  prog_addr_d;
   logic [INSN_W-1:0] prog_wdata_q, prog_wdata_d;
   logic              cmd_err_q,    cmd_err_d;
   // Set during the first RUN cycle so a resume from the breakpoint address proceeds.
   logic              first_run_q,  first_run_d;

   logic              cmd_acc_s;
   logic              bp_stop_s;
   dbg_op_e           op_s;

   assign op_s      = dbg_op_e'(cmd_op);
   assign cmd_ready = (state_q != ST_STEP);
   assign cmd_acc_s = cmd_valid & cmd_ready;
   assign bp_stop_s = (state_q == ST_RUN) & bp_en_q & (pc_in == bp_addr_q) & ~first_run_q;

   assign cpu_nReset = (state_q != ST_LOAD);
   assign halted     = is_stopped(state_q);
   assign prog_we    = prog_we_q;
   assign prog_addr  = prog_addr_q;
   assign prog_wdata = prog_wdata_q;
   assign bp_hit     = bp_hit_q;
   assign cmd_err    = cmd_err_q;

   // CPU clock enable: gated off in the very cycle a breakpoint address is seen.
   always_comb begin
      cpu_clk_en = 1'b0;
      case (state_q)
         ST_RUN:  cpu_clk_en = ~bp_stop_s;
         ST_STEP: cpu_clk_en = 1'b1;
         default: cpu_clk_en = 1'b0;
      endcase
   end

   // Command decode and next-state logic.
   always_comb begin
      state_d      = state_q;
      load_addr_d  = load_addr_q;
      bp_addr_d    = bp_addr_q;
      bp_en_d      = bp_en_q;
      bp_hit_d     = bp_hit_q;
      prog_we_d    = 1'b0;
      prog_addr_d  = prog_addr_q;
      prog_wdata_d = prog_wdata_q;
      cmd_err_d    = 1'b0;
      first_run_d  = 1'b0;
      case (state_q)
         ST_LOAD, ST_HALT: begin
            if (cmd_acc_s) begin
               case (op_s)
                  OP_CPU_RST: state_d = ST_LOAD;
                  OP_ADDR_HI: load_addr_d[PC_W-1:8] = cmd_data[PC_W-9:0];
                  OP_ADDR_LO: load_addr_d[7:0] = cmd_data[7:0];
                  OP_WRITE: begin
                     prog_we_d    = 1'b1;
                     prog_addr_d  = load_addr_q;
                     prog_wdata_d = cmd_data;
                     load_addr_d  = load_addr_q + PC_W'(1);
                  end
                  OP_RUN: begin
                     state_d     = ST_RUN;
                     bp_hit_d    = 1'b0;
                     first_run_d = 1'b1;
                  end
                  OP_STEP: state_d = ST_STEP;
                  OP_HALT: state_d = state_q;
                  OP_BP: begin
                     bp_addr_d = load_addr_q;
                     bp_en_d   = cmd_data[0];
                  end
                  default: state_d = state_q;
               endcase
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (bp_stop_s) begin
               state_d  = ST_HALT;
               bp_hit_d = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
            if (cmd_acc_s) begin
               case (op_s)
                  OP_CPU_RST: state_d = ST_LOAD;
                  OP_HALT:    state_d = ST_HALT;
                  default:    cmd_err_d = 1'b1;
               endcase
            end else begin
               cmd_err_d = 1'b0;
            end
         end
         ST_STEP: state_d = ST_HALT;
         default: state_d = ST_LOAD;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         state_q      <= ST_LOAD;
         load_addr_q  <= '0;
         bp_addr_q    <= '0;
         bp_en_q      <= 1'b0;
         bp_hit_q     <= 1'b0;
         prog_we_q    <= 1'b0;
         prog_addr_q  <= '0;
         prog_wdata_q <= '0;
         cmd_err_q    <= 1'b0;
         first_run_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_addr_q  <= load_addr_d;
         bp_addr_q    <= bp_addr_d;
         bp_en_q      <= bp_en_d;
         bp_hit_q     <= bp_hit_d;
         prog_we_q    <= prog_we_d;
         prog_addr_q  <= prog_addr_d;
         prog_wdata_q <= prog_wdata_d;
         cmd_err_q    <= cmd_err_d;
         first_run_q  <= first_run_d;
      end
   end

endmodule

// File: tb/tb_hc4_dbg_ctrl.sv
// Self-checking bench for hc4_dbg_ctrl: program writes are scoreboarded,
// control outputs are compared against constants derived from the command sequence.
module tb_hc4_dbg_ctrl;
   import hc4_dbg_pkg::*;

   localparam int PC_W   = 12;
   localparam int INSN_W = 8;

   logic              clk = 1'b0;
   logic              nReset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [INSN_W-1:0] cmd_data;
   logic [PC_W-1:0]   pc_in = '0;
   logic              cpu_nReset;
   logic              cpu_clk_en;
   logic              prog_we;
   logic [PC_W-1:0]   prog_addr;
   logic [INSN_W-1:0] prog_wdata;
   logic              halted;
   logic              bp_hit;
   logic              cmd_err;

   int n_chk  = 0;
   int n_fail = 0;
   logic [19:0] exp_wr_q[$];

   hc4_dbg_ctrl #(.PC_W(PC_W), .INSN_W(INSN_W)) dut (
      .clk        (clk),
      .nReset     (nReset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .pc_in      (pc_in),
      .cpu_nReset (cpu_nReset),
      .cpu_clk_en (cpu_clk_en),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata),
      .halted     (halted),
      .bp_hit     (bp_hit),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   // Simple CPU model: pc clears in reset and advances one step per enabled cycle.
   always @(posedge clk) begin
      if (cpu_nReset !== 1'b1) pc_in <= '0;
      else if (cpu_clk_en === 1'b1) pc_in <= pc_in + 12'd1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every prog_we cycle must match the next expected write.
   always @(negedge clk) begin
      if (prog_we === 1'b1) begin
         if (exp_wr_q.size() == 0) begin
            check_eq("unexpected_write", {prog_addr, prog_wdata}, 32'hFFFFFFFF);
         end else begin
            check_eq("prog_write", {12'd0, prog_addr, prog_wdata}, {12'd0, exp_wr_q.pop_front()});
         end
      end
   end

   // Present one command for one cycle; it is accepted at the next rising edge.
   task automatic send(input logic [2:0] op, input logic [7:0] data);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic write_word(input logic [11:0] addr, input logic [7:0] data);
      exp_wr_q.push_back({addr, data});
      send(3'(OP_WRITE), data);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  cyc;
      logic seen;
      nReset    = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_data  = 8'd0;
      tick();
      tick();
      // Reset state
      check_eq("rst_halted",   halted,     1'b1);
      check_eq("rst_cpu_nrst", cpu_nReset, 1'b0);
      check_eq("rst_clk_en",   cpu_clk_en, 1'b0);
      check_eq("rst_prog_we",  prog_we,    1'b0);
      check_eq("rst_addr",     prog_addr,  12'h000);
      check_eq("rst_bp_hit",   bp_hit,     1'b0);
      check_eq("rst_cmd_err",  cmd_err,    1'b0);
      @(negedge clk);
      nReset = 1'b1;
      #1;
      check_eq("rst_ready", cmd_ready, 1'b1);

      // Sequential load at 0x0FE
      send(3'(OP_ADDR_HI), 8'h00);
      send(3'(OP_ADDR_LO), 8'hFE);
      write_word(12'h0FE, 8'hA1);
      check_eq("load_halted", halted, 1'b1);
      write_word(12'h0FF, 8'hB2);
      check_eq("load_cpu_nrst", cpu_nReset, 1'b0);
      tick();
      check_eq("load_we_done", prog_we, 1'b0);

      // Address wrap at top of program memory
      send(3'(OP_ADDR_HI), 8'h0F);
      send(3'(OP_ADDR_LO), 8'hFF);
      write_word(12'hFFF, 8'h11);
      write_word(12'h000, 8'h22);
      tick();

      // Single step from LOAD
      send(3'(OP_STEP), 8'h00);
      check_eq("step_clk_en", cpu_clk_en, 1'b1);
      check_eq("step_cpu_nrst", cpu_nReset, 1'b1);
      check_eq("step_ready", cmd_ready, 1'b0);
      check_eq("step_halted", halted, 1'b0);
      tick();
      check_eq("step_done_clk_en", cpu_clk_en, 1'b0);
      check_eq("step_done_halted", halted, 1'b1);
      check_eq("step_done_ready", cmd_ready, 1'b1);
      check_eq("step_done_nrst", cpu_nReset, 1'b1);
      check_eq("step_pc", pc_in, 12'h001);

      // Breakpoint at 0x005
      send(3'(OP_ADDR_HI), 8'h00);
      send(3'(OP_ADDR_LO), 8'h05);
      send(3'(OP_BP), 8'h01);
      send(3'(OP_RUN), 8'h00);
      check_eq("run_state", halted, 1'b0);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         if (cpu_clk_en === 1'b0) seen = 1'b1;
         cyc++;
      end
      check_eq("bp_seen", seen, 1'b1);
      check_eq("bp_pc", pc_in, 12'h005);
      tick();
      check_eq("bp_halted", halted, 1'b1);
      check_eq("bp_hit", bp_hit, 1'b1);
      check_eq("bp_pc_hold", pc_in, 12'h005);

      // Resume past the breakpoint
      send(3'(OP_RUN), 8'h00);
      check_eq("resume_bp_hit", bp_hit, 1'b0);
      check_eq("resume_clk_en", cpu_clk_en, 1'b1);
      tick();
      check_eq("resume_pc", pc_in, 12'h006);
      check_eq("resume_running", halted, 1'b0);

      // Illegal commands while running
      send(3'(OP_WRITE), 8'h33);
      check_eq("run_write_err", cmd_err, 1'b1);
      tick();
      check_eq("run_err_pulse", cmd_err, 1'b0);
      send(3'(OP_RUN), 8'h00);
      check_eq("run_run_err", cmd_err, 1'b1);
      check_eq("run_run_state", halted, 1'b0);
      send(3'(OP_HALT), 8'h00);
      check_eq("halt_halted", halted, 1'b1);
      check_eq("halt_clk_en", cpu_clk_en, 1'b0);
      check_eq("halt_no_err", cmd_err, 1'b0);

      // Reset in the middle of RUN
      send(3'(OP_RUN), 8'h00);
      tick();
      @(negedge clk);
      nReset = 1'b0;
      tick();
      check_eq("midrst_halted", halted, 1'b1);
      check_eq("midrst_nrst", cpu_nReset, 1'b0);
      check_eq("midrst_clk_en", cpu_clk_en, 1'b0);
      @(negedge clk);
      nReset = 1'b1;
      write_word(12'h000, 8'h44);
      send(3'(OP_RUN), 8'h00);
      repeat (10) tick();
      check_eq("midrst_bp_off", halted, 1'b0);
      check_eq("midrst_pc_past", pc_in > 12'h005, 1'b1);

      repeat (3) tick();
      check_eq("writes_drained", exp_wr_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
